// File: rtl/video_pkg.sv
// Shared definitions for the video colour post-processing path:
// monitor mode encoding and luma weighting.
package video_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_COLOUR = 2'd0;
    localparam mode_t MODE_GREEN  = 2'd1;
    localparam mode_t MODE_AMBER  = 2'd2;
    localparam mode_t MODE_GREY   = 2'd3;

    // Luma approximation: (2*R + 5*G + 1*B) / 8
    localparam int unsigned LUMA_WR    = 2;
    localparam int unsigned LUMA_WG    = 5;
    localparam int unsigned LUMA_WB    = 1;
    localparam int unsigned LUMA_SHIFT = 3;

endpackage

// File: rtl/video_tint_filter_tint_map.sv
// Combinational channel mapper: turns luma plus original RGB into the
// colour of the selected monitor type.
module tint_map
    import video_pkg::*;
#(
    parameter int unsigned CW = 3
) (
    input  logic [CW-1:0] y,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    input  mode_t         eff,
    output logic [CW-1:0] r_c,
    output logic [CW-1:0] g_c,
    output logic [CW-1:0] b_c
);

    always_comb begin
        r_c = r;
        g_c = g;
        b_c = b;
        case (eff)
            MODE_GREEN: begin
                r_c = y >> 2;
                g_c = y;
                b_c = y >> 3;
            end
            MODE_AMBER: begin
                // 3/4 of luma on green gives the orange phosphor hue
                r_c = y;
                g_c = (y >> 1) + (y >> 2);
                b_c = '0;
            end
            MODE_GREY: begin
                r_c = y;
                g_c = y;
                b_c = y;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/video_tint_filter.sv
// Registered colour post-processor: frame-synchronised monitor mode,
// two-stage pixel pipeline with odd-line dimming and matching sync delay.
module video_tint_filter
    import video_pkg::*;
#(
    parameter int unsigned CW           = 3,
    parameter int unsigned DIM_SHIFT    = 1,
    parameter int unsigned DEFAULT_MODE = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [CW-1:0] ri,
    input  logic [CW-1:0] gi,
    input  logic [CW-1:0] bi,
    input  logic          hsync_n_in,
    input  logic          vsync_n_in,
    input  logic          mono_hw,
    input  logic          mode_step,
    input  logic          mode_load,
    input  logic [1:0]    mode_val,
    input  logic          dim_en,
    output logic [CW-1:0] ro,
    output logic [CW-1:0] go,
    output logic [CW-1:0] bo,
    output logic          hsync_n_out,
    output logic          vsync_n_out,
    output mode_t         mode
);

    localparam int unsigned SW       = CW + 3;
    localparam mode_t       RST_MODE = 2'(DEFAULT_MODE);

    logic          step_prev;
    mode_t         pending;
    logic          hs_prev;
    logic          vs_prev;
    logic          line_odd;

    logic [SW-1:0] luma_sum;
    logic [CW-1:0] luma;
    mode_t         eff;

    logic [CW-1:0] s1_y;
    logic [CW-1:0] s1_r;
    logic [CW-1:0] s1_g;
    logic [CW-1:0] s1_b;
    mode_t         s1_eff;
    logic          s1_odd;
    logic          s1_hs;
    logic          s1_vs;

    logic [CW-1:0] map_r;
    logic [CW-1:0] map_g;
    logic [CW-1:0] map_b;
    logic [CW-1:0] px_r;
    logic [CW-1:0] px_g;
    logic [CW-1:0] px_b;

    logic          hs_fall;
    logic          vs_fall;

    // Pending mode: keyboard step edge or direct load, load wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_prev <= 1'b0;
            pending   <= RST_MODE;
        end else begin
            step_prev <= mode_step;
            if (mode_load) begin
                pending <= mode_val;
            end else if (mode_step && !step_prev) begin
                pending <= pending + 2'd1;
            end
        end
    end

    assign hs_fall = hs_prev && !hsync_n_in;
    assign vs_fall = vs_prev && !vsync_n_in;

    // Line parity and frame-boundary mode commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev  <= 1'b1;
            vs_prev  <= 1'b1;
            line_odd <= 1'b0;
            mode     <= RST_MODE;
        end else if (ce) begin
            hs_prev <= hsync_n_in;
            vs_prev <= vsync_n_in;
            if (vs_fall) begin
                line_odd <= 1'b0;
                mode     <= pending;
            end else if (hs_fall) begin
                line_odd <= !line_odd;
            end
        end
    end

    assign luma_sum = SW'(LUMA_WR) * SW'(ri) + SW'(LUMA_WG) * SW'(gi) + SW'(LUMA_WB) * SW'(bi);
    assign luma     = CW'(luma_sum >> LUMA_SHIFT);
    assign eff      = (mono_hw && mode == MODE_COLOUR) ? MODE_GREEN : mode;

    // Stage 1: luma, raw pixel and per-pixel tags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_y   <= '0;
            s1_r   <= '0;
            s1_g   <= '0;
            s1_b   <= '0;
            s1_eff <= MODE_COLOUR;
            s1_odd <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
        end else if (ce) begin
            s1_y   <= luma;
            s1_r   <= ri;
            s1_g   <= gi;
            s1_b   <= bi;
            s1_eff <= eff;
            s1_odd <= line_odd;
            s1_hs  <= hsync_n_in;
            s1_vs  <= vsync_n_in;
        end
    end

    tint_map #(
        .CW (CW)
    ) u_tint_map (
        .y   (s1_y),
        .r   (s1_r),
        .g   (s1_g),
        .b   (s1_b),
        .eff (s1_eff),
        .r_c (map_r),
        .g_c (map_g),
        .b_c (map_b)
    );

    always_comb begin
        px_r = map_r;
        px_g = map_g;
        px_b = map_b;
        if (dim_en && s1_odd) begin
            px_r = map_r >> DIM_SHIFT;
            px_g = map_g >> DIM_SHIFT;
            px_b = map_b >> DIM_SHIFT;
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ro          <= '0;
            go          <= '0;
            bo          <= '0;
            hsync_n_out <= 1'b1;
            vsync_n_out <= 1'b1;
        end else if (ce) begin
            ro          <= px_r;
            go          <= px_g;
            bo          <= px_b;
            hsync_n_out <= s1_hs;
            vsync_n_out <= s1_vs;
        end
    end

endmodule
